// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: once per frame, erases all eight characters at their
// last-drawn positions, opens a one-cycle update window, then redraws every
// character one pixel per clock from the live position registers.
module sprite_frame_scheduler #(
  parameter logic [7:0] X_OFFSET = 8'd26,
  parameter logic [7:0] Y_OFFSET = 8'd1,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       frame_tick,
  output logic [2:0] character_type,
  input  logic [7:0] char_x,
  input  logic [7:0] char_y,
  output logic [2:0] sprite_px,
  output logic [2:0] sprite_py,
  input  logic       sprite_bit,
  input  logic [2:0] sprite_color,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       update_en,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

  state_t     state_q, state_d;
  logic [2:0] char_q, char_d;
  logic [2:0] px_q, px_d;
  logic [2:0] py_q, py_d;
  logic       snap_valid_q, snap_valid_d;
  logic       done_q, done_d;
  logic       overrun_q;

  // Last-drawn position of each character; read combinationally during ERASE.
  logic [7:0] snap_x_q [8];
  logic [7:0] snap_y_q [8];

  logic [7:0] base_x, base_y;
  logic       sweep_last;

  assign sweep_last = (px_q == 3'd4) && (py_q == 3'd4);

  // State, sweep counters and status pulses.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q      <= IDLE;
      char_q       <= 3'd0;
      px_q         <= 3'd0;
      py_q         <= 3'd0;
      snap_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      px_q         <= px_d;
      py_q         <= py_d;
      snap_valid_q <= snap_valid_d;
      done_q       <= done_d;
      overrun_q    <= frame_tick && (state_q != IDLE);
    end
  end

  // Capture the drawn position on the last pixel of each character in DRAW.
  always_ff @(posedge clock_50) begin
    if (state_q == DRAW && sweep_last) begin
      snap_x_q[char_q] <= char_x;
      snap_y_q[char_q] <= char_y;
    end
  end

  // Next-state logic: the 5x5x8 pixel sweep is shared by ERASE and DRAW.
  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    px_d         = px_q;
    py_d         = py_q;
    snap_valid_d = snap_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) state_d = snap_valid_q ? ERASE : UPDATE;
      end
      ERASE, DRAW: begin
        if (px_q == 3'd4) begin
          px_d = 3'd0;
          if (py_q == 3'd4) begin
            py_d   = 3'd0;
            char_d = char_q + 3'd1;  // wraps 7 -> 0 at end of sweep
            if (char_q == 3'd7) begin
              if (state_q == ERASE) begin
                state_d = UPDATE;
              end else begin
                state_d      = IDLE;
                snap_valid_d = 1'b1;
                done_d       = 1'b1;
              end
            end
          end else begin
            py_d = py_q + 3'd1;
          end
        end else begin
          px_d = px_q + 3'd1;
        end
      end
      UPDATE: state_d = DRAW;
      default: state_d = IDLE;
    endcase
  end

  // Plot port: erase uses the snapshot in background colour, draw uses live data.
  always_comb begin
    base_x    = snap_x_q[char_q];
    base_y    = snap_y_q[char_q];
    vga_plot  = 1'b0;
    vga_color = BG_COLOR;
    case (state_q)
      ERASE: vga_plot = 1'b1;
      DRAW: begin
        base_x    = char_x;
        base_y    = char_y;
        vga_plot  = sprite_bit;
        vga_color = sprite_color;
      end
      default: ;
    endcase
  end

  // 8-bit address arithmetic wraps modulo 256 by design.
  assign vga_x          = base_x + {5'b0, px_q} + X_OFFSET;
  assign vga_y          = base_y + {5'b0, py_q} + Y_OFFSET;
  assign character_type = char_q;
  assign sprite_px      = px_q;
  assign sprite_py      = py_q;
  assign update_en      = (state_q == UPDATE);
  assign busy           = (state_q != IDLE);
  assign frame_done     = done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Bench for sprite_frame_scheduler: directed frames with a behavioural model of
// the character registers and sprite ROM, table-driven pixel checks, and
// hand-written sequences for overrun, wrap and mid-frame reset.
module tb_sprite_frame_scheduler;

  logic       clock_50 = 1'b0;
  logic       reset, frame_tick;
  logic [2:0] character_type, sprite_px, sprite_py, sprite_color, vga_color;
  logic [7:0] char_x, char_y, vga_x, vga_y;
  logic       sprite_bit, vga_plot, update_en, busy, frame_done, overrun;

  logic [7:0] pos_x [8];
  logic [7:0] pos_y [8];
  logic [2:0] col   [8];

  // Per-cycle captures of a 200-cycle sweep; index 0 = erase, 1 = draw.
  logic       cap_plot [2][200];
  logic [7:0] cap_x    [2][200];
  logic [7:0] cap_y    [2][200];
  logic [2:0] cap_c    [2][200];
  logic       cap_busy [2][200];
  logic       cap_ovr  [2][200];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         ph;
    int         idx;
    logic       plot;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } vec_t;
  vec_t vt [13];

  always #5 clock_50 = ~clock_50;

  // Character registers and sprite ROM: only character 3 has a lit pixel, at (2,2).
  always_comb begin
    char_x       = pos_x[character_type];
    char_y       = pos_y[character_type];
    sprite_color = col[character_type];
    sprite_bit   = (character_type == 3'd3) && (sprite_px == 3'd2) && (sprite_py == 3'd2);
  end

  sprite_frame_scheduler dut (
    .clock_50(clock_50), .reset(reset), .frame_tick(frame_tick),
    .character_type(character_type), .char_x(char_x), .char_y(char_y),
    .sprite_px(sprite_px), .sprite_py(sprite_py), .sprite_bit(sprite_bit),
    .sprite_color(sprite_color), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_plot(vga_plot), .update_en(update_en),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    #1;
  endtask

  // Runs 200 cycles, recording outputs; optional position move at cycle 0 and
  // optional stray tick raised after cycle tick_at.
  task automatic run_sweep(input int ph, input int move, input int tick_at);
    for (int i = 0; i < 200; i++) begin
      step();
      frame_tick = 1'b0;
      if (move != 0 && i == 0) pos_x[3] = 8'd11;
      #1;
      cap_plot[ph][i] = vga_plot;
      cap_x[ph][i]    = vga_x;
      cap_y[ph][i]    = vga_y;
      cap_c[ph][i]    = vga_color;
      cap_busy[ph][i] = busy;
      cap_ovr[ph][i]  = overrun;
      if (i == tick_at) frame_tick = 1'b1;
    end
  endtask

  initial begin
    int cnt, first, bad_c, idle_busy;

    pos_x[0] = 8'd5;   pos_y[0] = 8'd2;
    pos_x[1] = 8'd30;  pos_y[1] = 8'd40;
    pos_x[2] = 8'd60;  pos_y[2] = 8'd60;
    pos_x[3] = 8'd10;  pos_y[3] = 8'd20;
    pos_x[4] = 8'd90;  pos_y[4] = 8'd80;
    pos_x[5] = 8'd120; pos_y[5] = 8'd100;
    pos_x[6] = 8'd150; pos_y[6] = 8'd120;
    pos_x[7] = 8'd250; pos_y[7] = 8'd100;
    for (int k = 0; k < 8; k++) col[k] = 3'b111;
    col[3] = 3'b001;

    // Expected pixels for frame 2 (erase from snapshot, draw with char 3 at x=11).
    vt[0]  = '{0, 0,   1'b1, 8'd31, 8'd3,   3'd0};
    vt[1]  = '{0, 24,  1'b1, 8'd35, 8'd7,   3'd0};
    vt[2]  = '{0, 25,  1'b1, 8'd56, 8'd41,  3'd0};
    vt[3]  = '{0, 75,  1'b1, 8'd36, 8'd21,  3'd0};
    vt[4]  = '{0, 87,  1'b1, 8'd38, 8'd23,  3'd0};
    vt[5]  = '{0, 99,  1'b1, 8'd40, 8'd25,  3'd0};
    vt[6]  = '{0, 175, 1'b1, 8'd20, 8'd101, 3'd0};
    vt[7]  = '{0, 179, 1'b1, 8'd24, 8'd101, 3'd0};
    vt[8]  = '{0, 199, 1'b1, 8'd24, 8'd105, 3'd0};
    vt[9]  = '{1, 0,   1'b0, 8'd0,  8'd0,   3'd0};
    vt[10] = '{1, 86,  1'b0, 8'd0,  8'd0,   3'd0};
    vt[11] = '{1, 87,  1'b1, 8'd39, 8'd23,  3'd1};
    vt[12] = '{1, 88,  1'b0, 8'd0,  8'd0,   3'd0};

    // Reset state.
    reset = 1'b1; frame_tick = 1'b0;
    step(); step(); step();
    chk("rst vga_plot", vga_plot, 1'b0);
    chk("rst update_en", update_en, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst character_type", character_type, 3'd0);
    chk("rst sprite_px", sprite_px, 3'd0);
    chk("rst sprite_py", sprite_py, 3'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Frame 1: no snapshot yet, so straight to UPDATE.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("f1 update_en at T+1", update_en, 1'b1);
    chk("f1 busy at T+1", busy, 1'b1);
    chk("f1 vga_plot at T+1", vga_plot, 1'b0);
    run_sweep(1, 0, -1);
    cnt = 0; first = -1; idle_busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (cap_plot[1][i] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (cap_busy[1][i] !== 1'b1) idle_busy++;
    end
    chk("f1 draw plot count", cnt, 1);
    chk("f1 draw plot cycle", first, 87);
    chk("f1 draw x", cap_x[1][87], 8'd38);
    chk("f1 draw y", cap_y[1][87], 8'd23);
    chk("f1 draw color", cap_c[1][87], 3'b001);
    chk("f1 draw busy-low cycles", idle_busy, 0);
    step();
    chk("f1 frame_done at T+202", frame_done, 1'b1);
    chk("f1 busy at T+202", busy, 1'b0);
    step();
    chk("f1 frame_done pulse ends", frame_done, 1'b0);
    step(); step();

    // Frame 2: erase from snapshot, move character 3 after the update window.
    frame_tick = 1'b1;
    run_sweep(0, 0, -1);
    step();
    chk("f2 update_en at T+201", update_en, 1'b1);
    chk("f2 vga_plot in update", vga_plot, 1'b0);
    run_sweep(1, 1, -1);
    step();
    chk("f2 frame_done at T+402", frame_done, 1'b1);
    cnt = 0; bad_c = 0; idle_busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (cap_plot[0][i] === 1'b1) cnt++;
      if (cap_c[0][i] !== 3'b000) bad_c++;
      if (cap_busy[0][i] !== 1'b1) idle_busy++;
    end
    chk("f2 erase plot count", cnt, 200);
    chk("f2 erase non-bg colours", bad_c, 0);
    chk("f2 erase busy-low cycles", idle_busy, 0);
    for (int v = 0; v < 13; v++) begin
      chk($sformatf("vec%0d ph%0d idx%0d plot", v, vt[v].ph, vt[v].idx),
          cap_plot[vt[v].ph][vt[v].idx], vt[v].plot);
      if (vt[v].plot) begin
        chk($sformatf("vec%0d x", v), cap_x[vt[v].ph][vt[v].idx], vt[v].x);
        chk($sformatf("vec%0d y", v), cap_y[vt[v].ph][vt[v].idx], vt[v].y);
        chk($sformatf("vec%0d color", v), cap_c[vt[v].ph][vt[v].idx], vt[v].c);
      end
    end
    step(); step();

    // Frame 3: erase must use the moved position; stray tick during DRAW.
    frame_tick = 1'b1;
    run_sweep(0, 0, -1);
    chk("f3 erase char3 x", cap_x[0][75], 8'd37);
    step();
    chk("f3 update_en", update_en, 1'b1);
    run_sweep(1, 0, 10);
    cnt = 0;
    for (int i = 0; i < 200; i++) if (cap_ovr[1][i] === 1'b1) cnt++;
    chk("f3 overrun pulse count", cnt, 1);
    chk("f3 overrun cycle after tick", cap_ovr[1][11], 1'b1);
    step();
    chk("f3 frame_done on time", frame_done, 1'b1);
    idle_busy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy !== 1'b0) idle_busy++;
    end
    chk("f3 no extra frame", idle_busy, 0);

    // Reset during ERASE cycle 50, then the next tick must skip ERASE.
    frame_tick = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      step();
      frame_tick = 1'b0;
    end
    chk("mid erase vga_plot", vga_plot, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort vga_plot", vga_plot, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort character_type", character_type, 3'd0);
    step(); step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("post-reset update_en (no erase)", update_en, 1'b1);
    run_sweep(1, 0, -1);
    step();
    chk("post-reset frame_done", frame_done, 1'b1);
    // A tick in the frame_done cycle is accepted and now erases.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("tick on frame_done busy", busy, 1'b1);
    chk("tick on frame_done erase plot", vga_plot, 1'b1);
    chk("tick on frame_done overrun", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
